// File: rtl/mem_pkg.sv
// Shared definitions for the burst memory read/write FSMs.
package mem_pkg;

    localparam int unsigned WORDS  = 16;
    localparam int unsigned DW     = 16;
    localparam int unsigned AW     = 16;
    localparam int unsigned LINE_W = WORDS * DW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Word idx of a line buffer; word 0 occupies the least significant bits.
    function automatic logic [DW-1:0] word_sel(input logic [LINE_W-1:0] line,
                                               input int unsigned idx);
        return line[idx*DW +: DW];
    endfunction

endpackage

// File: rtl/mem_write_shifter.sv
// Shadow line buffer and write mask; shifts down one word per write cycle.
module mem_write_shifter
    import mem_pkg::*;
#(
    parameter int unsigned WORDS = mem_pkg::WORDS,
    parameter int unsigned DW    = mem_pkg::DW
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                load,
    input  logic                shift,
    input  logic [WORDS*DW-1:0] line,
    input  logic [WORDS-1:0]    mask,
    output logic [DW-1:0]       word_c,
    output logic                mask_c
);

    logic [WORDS*DW-1:0] buf_q;
    logic [WORDS-1:0]    mask_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            buf_q  <= '0;
            mask_q <= '0;
        end else if (load) begin
            buf_q  <= line;
            mask_q <= mask;
        end else if (shift) begin
            buf_q  <= buf_q >> DW;
            mask_q <= mask_q >> 1;
        end
    end

    // Head of the shift register is always the next word to write.
    always_comb begin
        word_c = DW'(word_sel(LINE_W'(buf_q), 32'd0));
        mask_c = mask_q[0];
    end

endmodule

// File: rtl/mem_write_fsm.sv
// Burst memory writer: captures a line and base address, then writes WORDS words.
module mem_write_fsm
    import mem_pkg::*;
#(
    parameter int unsigned WORDS = mem_pkg::WORDS,
    parameter int unsigned DW    = mem_pkg::DW,
    parameter int unsigned AW    = mem_pkg::AW
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                start,
    input  logic [AW-1:0]       AddrIn,
    input  logic [WORDS*DW-1:0] DataBuff,
    input  logic [WORDS-1:0]    WrMask,
    output logic [AW-1:0]       Addr,
    output logic                WR,
    output logic [DW-1:0]       DataIn,
    output logic                busy,
    output logic                done_vld
);

    localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   base_q, base_d;
    logic [AW-1:0]   addr_d;
    logic [DW-1:0]   data_d;
    logic            wr_d, busy_d, done_d;
    logic            load_c, shift_c;
    logic [DW-1:0]   word_c;
    logic            mask_c;

    mem_write_shifter #(
        .WORDS (WORDS),
        .DW    (DW)
    ) u_shifter (
        .Clk    (Clk),
        .Rst    (Rst),
        .load   (load_c),
        .shift  (shift_c),
        .line   (DataBuff),
        .mask   (WrMask),
        .word_c (word_c),
        .mask_c (mask_c)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            base_q   <= '0;
            Addr     <= '0;
            DataIn   <= '0;
            WR       <= 1'b0;
            busy     <= 1'b0;
            done_vld <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            Addr     <= addr_d;
            DataIn   <= data_d;
            WR       <= wr_d;
            busy     <= busy_d;
            done_vld <= done_d;
        end
    end

    // Addr/DataIn hold outside WRITE; WR alone qualifies them.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        addr_d  = Addr;
        data_d  = DataIn;
        wr_d    = 1'b0;
        busy_d  = busy;
        done_d  = 1'b0;
        load_c  = 1'b0;
        shift_c = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    load_c  = 1'b1;
                    base_d  = AddrIn;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                addr_d  = base_q + AW'(cnt_q);
                data_d  = word_c;
                wr_d    = mask_c;
                shift_c = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WORDS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_write_fsm.sv
// Directed bench for mem_write_fsm: table-driven bursts plus hand-written corner sequences.
module tb_mem_write_fsm;

    localparam int unsigned WORDS = 16;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 16;

    logic                Clk;
    logic                Rst;
    logic                start;
    logic [AW-1:0]       AddrIn;
    logic [WORDS*DW-1:0] DataBuff;
    logic [WORDS-1:0]    WrMask;
    logic [AW-1:0]       Addr;
    logic                WR;
    logic [DW-1:0]       DataIn;
    logic                busy;
    logic                done_vld;

    int errors = 0;
    int checks = 0;

    mem_write_fsm dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .start    (start),
        .AddrIn   (AddrIn),
        .DataBuff (DataBuff),
        .WrMask   (WrMask),
        .Addr     (Addr),
        .WR       (WR),
        .DataIn   (DataIn),
        .busy     (busy),
        .done_vld (done_vld)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] base;
        logic [15:0] mask;
        logic [15:0] seed;
        logic [15:0] exp_last_addr;
        int          exp_writes;
    } burst_vec_t;

    burst_vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_inputs(input logic [15:0] base, input logic [15:0] mask, input logic [15:0] seed);
        AddrIn = base;
        WrMask = mask;
        for (int i = 0; i < int'(WORDS); i++) begin
            DataBuff[i*DW +: DW] = seed + 16'(i);
        end
    endtask

    // Called just after the accepting edge k; returns just after edge k+17.
    task automatic burst_body(input burst_vec_t v, input bit disturb);
        int wr_count = 0;
        logic [15:0] exp_addr;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("wr_after_accept", 32'(WR), 32'd0);
        for (int i = 0; i < int'(WORDS); i++) begin
            step();
            if (disturb && i == 4) begin
                set_inputs(16'h5555, 16'h0000, 16'hDEAD);
                start = 1'b1;
            end else if (disturb && i == 5) begin
                start = 1'b0;
            end
            exp_addr = v.base + 16'(i);
            check("addr", 32'(Addr), 32'(exp_addr));
            check("data", 32'(DataIn), 32'(v.seed + 16'(i)));
            check("wr", 32'(WR), 32'(v.mask[i]));
            check("busy_in_burst", 32'(busy), 32'd1);
            check("done_early", 32'(done_vld), 32'd0);
            if (WR) wr_count++;
        end
        step();
        check("done_pulse", 32'(done_vld), 32'd1);
        check("wr_in_done", 32'(WR), 32'd0);
        check("busy_in_done", 32'(busy), 32'd1);
        check("addr_hold", 32'(Addr), 32'(v.exp_last_addr));
        check("write_count", 32'(wr_count), 32'(v.exp_writes));
    endtask

    initial begin
        vecs[0] = '{base: 16'h0080, mask: 16'hFFFF, seed: 16'h000F, exp_last_addr: 16'h008F, exp_writes: 16};
        vecs[1] = '{base: 16'hFFFA, mask: 16'hFFFF, seed: 16'h1000, exp_last_addr: 16'h0009, exp_writes: 16};
        vecs[2] = '{base: 16'h0200, mask: 16'h00F0, seed: 16'hA500, exp_last_addr: 16'h020F, exp_writes: 4};
        vecs[3] = '{base: 16'h1234, mask: 16'h0000, seed: 16'h0001, exp_last_addr: 16'h1243, exp_writes: 0};

        Rst = 1'b1;
        start = 1'b0;
        AddrIn = '0;
        WrMask = '0;
        DataBuff = '0;
        #2;
        check("rst_addr", 32'(Addr), 32'd0);
        check("rst_data", 32'(DataIn), 32'd0);
        check("rst_wr", 32'(WR), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done_vld), 32'd0);
        step();
        step();
        Rst = 1'b0;
        step();

        // Table-driven bursts, each followed by an idle cycle check.
        for (int n = 0; n < 4; n++) begin
            set_inputs(vecs[n].base, vecs[n].mask, vecs[n].seed);
            start = 1'b1;
            step();
            start = 1'b0;
            burst_body(vecs[n], 1'b0);
            step();
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done_vld), 32'd0);
            step();
        end

        // Start and input changes while busy must not disturb the burst.
        set_inputs(vecs[0].base, vecs[0].mask, vecs[0].seed);
        start = 1'b1;
        step();
        start = 1'b0;
        burst_body(vecs[0], 1'b1);
        step();
        check("no_requeue_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("no_requeue_wr", 32'(WR), 32'd0);
            check("no_requeue_busy2", 32'(busy), 32'd0);
        end

        // Reset after the 6th write aborts immediately.
        set_inputs(vecs[2].base, 16'hFFFF, vecs[2].seed);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("pre_rst_wr", 32'(WR), 32'd1);
        check("pre_rst_addr", 32'(Addr), 32'(16'h0205));
        #1;
        Rst = 1'b1;
        #1;
        check("abort_wr", 32'(WR), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_addr", 32'(Addr), 32'd0);
        check("abort_data", 32'(DataIn), 32'd0);
        step();
        Rst = 1'b0;
        for (int c = 0; c < 14; c++) begin
            step();
            check("post_rst_done", 32'(done_vld), 32'd0);
            check("post_rst_wr", 32'(WR), 32'd0);
        end
        set_inputs(vecs[0].base, vecs[0].mask, vecs[0].seed);
        start = 1'b1;
        step();
        start = 1'b0;
        burst_body(vecs[0], 1'b0);
        step();

        // Back-to-back: start held high, next burst accepted at k+18.
        set_inputs(vecs[0].base, vecs[0].mask, vecs[0].seed);
        start = 1'b1;
        step();
        burst_body(vecs[0], 1'b0);
        set_inputs(vecs[2].base, vecs[2].mask, vecs[2].seed);
        step();
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_gap_wr", 32'(WR), 32'd0);
        check("b2b_gap_done", 32'(done_vld), 32'd0);
        start = 1'b0;
        burst_body(vecs[2], 1'b0);
        step();
        check("b2b_end_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
